// File: rtl/tea_decrypt_core.sv
// Iterative TEA decryption engine: buffers an 8-byte ciphertext block, runs the
// TEA decryption cycles and streams the plaintext out MSB first. Optional macro
// TEA_DECRYPT_UNROLL2_EN chains two TEA cycles per clock.
module tea_decrypt_core #(
    parameter logic [31:0] TEA_DELTA  = 32'h9E3779B9,
    parameter int          NUM_CYCLES = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_calculate,
    input  logic [7:0]       i_cipher_update,
    input  logic             i_cipher_update_valid,
    input  logic [3:0][31:0] i_round_key_data,
    input  logic             i_round_key_valid,
    output logic             o_decrypted_valid,
    output logic [7:0]       o_decrypted_data,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(NUM_CYCLES);
`ifdef TEA_DECRYPT_UNROLL2_EN
    localparam int          RUN_CLOCKS = NUM_CYCLES / 2;
    localparam logic [31:0] SUM_STEP   = 32'(TEA_DELTA * 32'd2);
`else
    localparam int          RUN_CLOCKS = NUM_CYCLES;
    localparam logic [31:0] SUM_STEP   = TEA_DELTA;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CLOCKS - 1);
    localparam logic [31:0]      SUM_INIT = 32'(TEA_DELTA * 32'(NUM_CYCLES));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [63:0]      blk_reg;
    logic [31:0]      sum_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       ocnt_reg;
    logic             valid_reg;
    logic [7:0]       data_reg;
    logic             busy_reg;

    logic [63:0]      blk_next;
    logic [7:0]       blk_byte [8];

    function automatic logic [31:0] tea_mix(
        input logic [31:0] v,
        input logic [31:0] s,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    // One decryption cycle: v1 is updated first, then v0 uses the new v1.
    function automatic logic [63:0] tea_dec_cycle(
        input logic [63:0]      blk,
        input logic [31:0]      s,
        input logic [3:0][31:0] k
    );
        logic [31:0] v0;
        logic [31:0] v1;
        v0 = blk[63:32];
        v1 = blk[31:0];
        v1 = v1 - tea_mix(v0, s, k[2], k[3]);
        v0 = v0 - tea_mix(v1, s, k[0], k[1]);
        return {v0, v1};
    endfunction

`ifdef TEA_DECRYPT_UNROLL2_EN
    logic [63:0] blk_mid;

    always_comb begin
        blk_mid  = tea_dec_cycle(blk_reg, sum_reg, i_round_key_data);
        blk_next = tea_dec_cycle(blk_mid, sum_reg - TEA_DELTA, i_round_key_data);
    end
`else
    always_comb begin
        blk_next = tea_dec_cycle(blk_reg, sum_reg, i_round_key_data);
    end
`endif

    // Byte 0 is the MSB of v0, i.e. the first byte on the wire.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_blk_byte
            assign blk_byte[gi] = blk_reg[63 - 8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            blk_reg   <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            ocnt_reg  <= '0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    if (i_cipher_update_valid) begin
                        blk_reg <= {blk_reg[55:0], i_cipher_update};
                    end
                    if (i_calculate && i_round_key_valid) begin
                        state_reg <= RUN;
                        sum_reg   <= SUM_INIT;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    blk_reg <= blk_next;
                    sum_reg <= sum_reg - SUM_STEP;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= OUT;
                        ocnt_reg  <= '0;
                    end
                end
                OUT: begin
                    // busy stays high through the edge after the last byte
                    valid_reg <= 1'b1;
                    data_reg  <= blk_byte[ocnt_reg];
                    ocnt_reg  <= ocnt_reg + 3'd1;
                    if (ocnt_reg == 3'd7) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_decrypted_valid = valid_reg;
    assign o_decrypted_data  = data_reg;
    assign o_busy            = busy_reg;

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Scoreboard bench for tea_decrypt_core: random TEA round trips against a
// behavioural encrypt/decrypt model, plus timing, reset and corner cases.
module tb_tea_decrypt_core;

    localparam logic [31:0] DELTA = 32'h9E3779B9;
`ifdef TEA_DECRYPT_UNROLL2_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif
    localparam int OCC = LAT + 8;

    logic             clk;
    logic             rst;
    logic             calc;
    logic [7:0]       cipher;
    logic             cipher_valid;
    logic [3:0][31:0] key;
    logic             key_valid;
    logic             dec_valid;
    logic [7:0]       dec_data;
    logic             busy;

    tea_decrypt_core dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_calculate           (calc),
        .i_cipher_update       (cipher),
        .i_cipher_update_valid (cipher_valid),
        .i_round_key_data      (key),
        .i_round_key_valid     (key_valid),
        .o_decrypted_valid     (dec_valid),
        .o_decrypted_data      (dec_data),
        .o_busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [31:0] mix(input logic [31:0] v, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [3:0][31:0] k);
        logic [31:0] v0 = p[63:32];
        logic [31:0] v1 = p[31:0];
        logic [31:0] s  = 32'd0;
        for (int i = 0; i < 32; i++) begin
            s  = s + DELTA;
            v0 = v0 + mix(v1, s, k[0], k[1]);
            v1 = v1 + mix(v0, s, k[2], k[3]);
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] ref_decrypt(input logic [63:0] c, input logic [3:0][31:0] k);
        logic [31:0] v0 = c[63:32];
        logic [31:0] v1 = c[31:0];
        logic [31:0] s  = 32'(DELTA * 32'd32);
        for (int i = 0; i < 32; i++) begin
            v1 = v1 - mix(v0, s, k[2], k[3]);
            v0 = v0 - mix(v1, s, k[0], k[1]);
            s  = s - DELTA;
        end
        return {v0, v1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_block(input int start, input logic [63:0] data);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.data = data[63 - 8*k -: 8];
            e.cyc  = start + LAT + k;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every valid byte must match the head of the scoreboard in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (dec_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got %h expected no output (cycle %0d)", dec_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("byte_data", 64'(dec_data), 64'(e.data));
                check("byte_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic load_bytes(input logic [63:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            cipher       = b[63 - 8*i -: 8];
            cipher_valid = 1'b1;
            @(negedge clk);
        end
        cipher_valid = 1'b0;
    endtask

    task automatic issue_start(input logic [63:0] exp_data, input bit expect_out, output int start);
        calc  = 1'b1;
        start = cyc + 1;
        if (expect_out) push_block(start, exp_data);
        $display("start at E%0d key %h expect %h", start, key, exp_data);
        @(negedge clk);
        calc = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int start, input int blocks);
        int t = 0;
        while (busy === 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("busy_fall_cycle", 64'(cyc), 64'(start + blocks*OCC));
    endtask

    task automatic new_key();
        for (int i = 0; i < 4; i++) key[i] = $urandom;
    endtask

    initial begin
        int          s;
        logic [63:0] p;
        logic [63:0] c;

        rst          = 1'b1;
        calc         = 1'b0;
        cipher       = 8'h00;
        cipher_valid = 1'b0;
        key          = '0;
        key_valid    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(dec_valid), 64'd0);
        check("reset_data", 64'(dec_data), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known vector: zero key, zero plaintext
        load_bytes(64'h41EA3A0A94BAA940, 8);
        issue_start(64'h0, 1'b1, s);
        wait_done(s, 1);

        // Start without a valid key is ignored
        key_valid = 1'b0;
        calc      = 1'b1;
        @(negedge clk);
        calc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("busy_no_key", 64'(busy), 64'd0);
            @(negedge clk);
        end
        key_valid = 1'b1;

        // Bytes and start pulses during RUN are ignored
        new_key();
        p = {$urandom, $urandom};
        c = ref_encrypt(p, key);
        load_bytes(c, 8);
        issue_start(p, 1'b1, s);
        for (int i = 0; i < 10; i++) begin
            cipher       = 8'($urandom);
            cipher_valid = 1'b1;
            calc         = (i % 3 == 0);
            @(negedge clk);
        end
        cipher_valid = 1'b0;
        calc         = 1'b0;
        wait_done(s, 1);

        // Reset at E20 of RUN aborts with no output
        new_key();
        load_bytes({$urandom, $urandom}, 8);
        issue_start(64'h0, 1'b0, s);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 64'(dec_valid), 64'd0);
        check("abort_data", 64'(dec_data), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        issue_start(ref_decrypt(64'h0, key), 1'b1, s);
        wait_done(s, 1);
        p = {$urandom, $urandom};
        load_bytes(ref_encrypt(p, key), 8);
        issue_start(p, 1'b1, s);
        wait_done(s, 1);

        // Start held high: back-to-back, second pass decrypts the retained plaintext
        new_key();
        p = {$urandom, $urandom};
        load_bytes(ref_encrypt(p, key), 8);
        calc = 1'b1;
        s    = cyc + 1;
        push_block(s, p);
        push_block(s + OCC, ref_decrypt(p, key));
        $display("back-to-back at E%0d key %h expect %h", s, key, p);
        repeat (OCC + 3) @(negedge clk);
        check("busy_back_to_back", 64'(busy), 64'd1);
        calc = 1'b0;
        wait_done(s, 2);

        // Random round trips, sometimes with the last byte on the start cycle
        for (int n = 0; n < 200; n++) begin
            new_key();
            p = {$urandom, $urandom};
            c = ref_encrypt(p, key);
            if ($urandom_range(1, 0) == 1) begin
                load_bytes(c, 7);
                cipher       = c[7:0];
                cipher_valid = 1'b1;
                issue_start(p, 1'b1, s);
                cipher_valid = 1'b0;
            end else begin
                load_bytes(c, 8);
                issue_start(p, 1'b1, s);
            end
            wait_done(s, 1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/tea_decrypt_core.md
# tea_decrypt_core

Iterative TEA decryption datapath: the receive-side counterpart of the encryption plaintext engine. It collects an 8-byte ciphertext block from the byte stream delivered by the frontend and takes the 128-bit key from the key block. On command it runs the 32 TEA decryption cycles and streams the 8 recovered plaintext bytes back to the frontend for UART transmission. It sits between the frontend and the key block of the decryption top level.

## Interface
- `TEA_DELTA`, `32'h9E3779B9`, TEA key schedule constant.
- `NUM_CYCLES`, `32`, TEA cycles (Feistel round pairs) per block; must be a power of 2, at least 2.
- `i_clk` input 1: single clock, all state on rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_calculate` input 1: start decryption of the buffered block.
- `i_cipher_update` input 8: ciphertext byte from the frontend.
- `i_cipher_update_valid` input 1: qualifies `i_cipher_update` for one cycle.
- `i_round_key_data` input [3:0][31:0]: key words, `k0 = [0]` … `k3 = [3]`.
- `i_round_key_valid` input 1: key block holds a complete key.
- `o_decrypted_valid` output 1: qualifies `o_decrypted_data`, one byte per cycle.
- `o_decrypted_data` output 8: recovered plaintext byte.
- `o_busy` output 1: high while not IDLE.

## Operation
- The block buffer is a 64-bit shift register `blk`.
  - Each accepted byte does `blk <= {blk[55:0], byte}`, so the first byte received ends up as the MSB of `v0`.
  - `v0 = blk[63:32]`, `v1 = blk[31:0]`.
  - Bytes are accepted only in IDLE. Bytes presented in RUN or OUT are dropped.
  - The buffer has no byte counter. The last 8 bytes received form the block.
- States are IDLE, RUN and OUT.
- IDLE → RUN: requires `i_calculate=1 && i_round_key_valid=1`.
  - On this transition: `sum <= TEA_DELTA*NUM_CYCLES` (truncated to 32 bits; `32'hC6EF3720` at default), `cnt <= 0`.
  - If `i_calculate=1` with `i_round_key_valid=0`, the request is ignored and the state stays IDLE.
  - If `i_calculate` and `i_cipher_update_valid` are high in the same cycle, the byte is shifted in first and the calculation uses the updated `blk`.
- RUN performs one TEA cycle per clock, all arithmetic mod 2^32. Each clock, in order:
  - `v1' = v1 - (((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3))`
  - `v0' = v0 - (((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1))`
  - `sum' = sum - TEA_DELTA`, `cnt++`
  - All shifts are logical.
- RUN → OUT when `cnt == NUM_CYCLES-1` and that cycle completes. `ocnt <= 0`.
- OUT emits the 8 bytes of `blk`, MSB of `v0` first, one per clock, with `o_decrypted_valid=1`. After the 8th byte: IDLE.
- `blk` keeps the plaintext after completion. A new `i_calculate` without new bytes decrypts it again.
- `i_round_key_data` is sampled every RUN cycle. The key must be held stable from the start request until `o_busy` falls. Key changes during RUN are not detected.
- `i_calculate` in RUN or OUT is ignored. There is no abort and no back-pressure: the frontend must accept one byte per cycle.

## Timing
- Reset values:
  - `o_decrypted_valid=0`, `o_decrypted_data=8'h00`, `o_busy=0`
  - state IDLE, `blk=0`, `sum=0`, `cnt=0`, `ocnt=0`
- Let E0 be the edge that accepts the start.
  - `o_busy=1` from after E0.
  - RUN cycles execute on E1..E32.
  - Byte k (k=0..7) is registered at E(33+k); `o_decrypted_valid` is high after E33 through E40.
  - At E41: `o_decrypted_valid=0`, `o_busy=0`, state IDLE. The next start can be accepted at E41 or later.
- Start-to-first-byte latency is 33 clocks. Total occupancy is 41 clocks.
- Reset asserted at any point, including mid-RUN or mid-OUT, returns every register to its reset value on that edge. No partial output follows.

## Configuration
- `TEA_DECRYPT_UNROLL2_EN`:
  - Defined: two TEA cycles are chained combinationally per clock. `sum` decrements by `2*TEA_DELTA` and RUN lasts `NUM_CYCLES/2` clocks. At default this is 16 clocks: output after E17..E24, IDLE at E25.
  - Undefined: one cycle per clock, as above.
  - Data results are identical in both builds.

## Test plan
- Key all zero, bytes `41 EA 3A 0A 94 BA A9 40`, calculate → after E33..E40 eight valid bytes `00`, `o_busy` falls at E41.
- Round trip: random key and plaintext encrypted by the reference model, fed as ciphertext → the original 8 bytes come back MSB first. Repeat for 200 random vectors.
- `i_calculate` with `i_round_key_valid=0` → no `o_busy`, no valid output. Bytes during RUN are ignored: the output is unchanged versus the same run without them.
- Reset asserted at E20 of RUN → all outputs 0 on the next cycle. A fresh load and start then produce correct output.
- Start request held high continuously → back-to-back blocks. Each block's 8 valid bytes follow its own 33-clock latency. The second decrypt of the retained `blk` is verified against the reference model.
- With `TEA_DECRYPT_UNROLL2_EN` defined, same vectors → identical data, first byte after E17, IDLE at E25.
